spi_ram_ctrl: RTL and testbench

Command-decoding synchronous RAM that sits directly downstream of the SPI slave. It consumes each 10-bit received word, `din`/`rx_valid`, as an opcode plus payload. It performs address-load, write and read operations on an internal byte-wide memory. Read results are returned to the slave on `dout`/`tx_valid` for serialisation onto MISO.

---
 rtl/spi_ram_pkg.sv | 19 +
 rtl/ram_array.sv | 25 ++
 rtl/spi_ram_ctrl.sv | 134 +++++++++++++
 tb/tb_spi_ram_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM state encoding and transmit-burst length for the SPI RAM controller.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    TX_BUSY = 1'b1
  } state_e;

  localparam int unsigned TX_BEATS = 8;
  localparam int unsigned TX_CNT_W = $clog2(TX_BEATS);

endpackage

// File: rtl/ram_array.sv
// Byte-wide storage: one synchronous write port, one registered read port, no reset.
module ram_array #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [MEM_DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI words into address-load / write / read commands on a byte RAM
// and returns each read byte to the SPI slave as an 8-cycle tx_valid burst.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(TX_BEATS - 1);

  opcode_e              op;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_armed_q, rd_armed_q;
  state_e               state_q;
  logic [TX_CNT_W-1:0]  tx_cnt_q;
  logic                 tx_valid_q, cmd_err_q, dout_live_q;
  logic                 wr_load, rd_load, wr_en, rd_en, wr_rej, rd_rej, rd_ready;
  logic [7:0]           rd_byte;

  assign op           = opcode_e'(din[9:8]);
  assign payload_addr = din[ADDR_SIZE-1:0];
  // The last busy cycle counts as free so back-to-back reads chain without a gap.
  assign rd_ready     = rd_armed_q && (state_q == IDLE || tx_cnt_q == TX_LAST);

  always_comb begin
    wr_load   = 1'b0;
    rd_load   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    wr_rej    = 1'b0;
    rd_rej    = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    if (rx_valid) begin
      unique case (op)
        OP_WR_ADDR: begin
          wr_load   = 1'b1;
          wr_addr_d = payload_addr;
        end
        OP_WR_DATA: begin
          if (wr_armed_q) begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            wr_rej = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_load   = 1'b1;
          rd_addr_d = payload_addr;
        end
        OP_RD_DATA: begin
          if (rd_ready) begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            rd_rej = 1'b1;
          end
        end
      endcase
    end
  end

  ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr_q),
    .wdata_i (din[7:0]),
    .re_i    (rd_en),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_cnt_q    <= '0;
      tx_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      dout_live_q <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_armed_q  <= 1'b0;
      rd_armed_q  <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      cmd_err_q <= wr_rej || rd_rej;
      if (wr_load) wr_armed_q <= 1'b1;
      if (rd_load) rd_armed_q <= 1'b1;
      if (rd_en)   dout_live_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (rd_en) begin
            state_q    <= TX_BUSY;
            tx_valid_q <= 1'b1;
            tx_cnt_q   <= '0;
          end
        end
        TX_BUSY: begin
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_q <= '0;
            if (!rd_en) begin
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + TX_CNT_W'(1);
          end
        end
      endcase
    end
  end

  // The RAM read register has no reset, so dout is forced to zero until a read lands.
  assign dout     = dout_live_q ? rd_byte : '0;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed scoreboard bench for spi_ram_ctrl: stimulus queues expected read bursts and
// rejection pulses; a negedge monitor compares tx_valid, dout and cmd_err every cycle.
module tb_spi_ram_ctrl;

  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_ERR  = 2;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  typedef struct {
    int         start;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t rdq[$];
  int      errq[$];
  rd_exp_t cur;
  logic    cur_act;
  int      cyc;
  int      n_checks;
  int      n_fails;

  spi_ram_ctrl #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected-vs-actual comparison set per cycle, away from the active edge.
  initial cur_act = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cur_act = 1'b0;
      chk("reset_tx_valid", {7'd0, tx_valid}, 8'h00);
      chk("reset_dout", dout, 8'h00);
      chk("reset_cmd_err", {7'd0, cmd_err}, 8'h00);
    end else begin
      logic exp_err;
      if (rdq.size() > 0 && rdq[0].start == cyc) begin
        cur     = rdq.pop_front();
        cur_act = 1'b1;
      end
      if (cur_act && cyc >= cur.start + 8) cur_act = 1'b0;
      chk("tx_valid", {7'd0, tx_valid}, {7'd0, cur_act});
      if (cur_act) chk("dout", dout, cur.data);
      exp_err = 1'b0;
      if (errq.size() > 0 && errq[0] == cyc) begin
        void'(errq.pop_front());
        exp_err = 1'b1;
      end
      chk("cmd_err", {7'd0, cmd_err}, {7'd0, exp_err});
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [7:0] pl, input int kind,
                     input logic [7:0] exp);
    @(negedge clk);
    din      = {op, pl};
    rx_valid = 1'b1;
    if (kind == K_RD) rdq.push_back('{start: cyc + 1, data: exp});
    else if (kind == K_ERR) errq.push_back(cyc + 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b0;
    din      = '0;
    rx_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Seed address 0 with 0x77, then reset so both arm flags are clear again.
    cmd(2'b00, 8'h00, K_NONE, 8'h00);
    cmd(2'b01, 8'h77, K_NONE, 8'h00);
    do_reset();

    // Unarmed write and read are both rejected.
    cmd(2'b01, 8'h5A, K_ERR, 8'h00);
    cmd(2'b11, 8'h00, K_ERR, 8'h00);
    idle(2);
    cmd(2'b10, 8'h00, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'h77);
    idle(9);

    // Basic address-load, write, read-back.
    cmd(2'b00, 8'h10, K_NONE, 8'h00);
    cmd(2'b01, 8'hA5, K_NONE, 8'h00);
    idle(2);
    cmd(2'b10, 8'h10, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'hA5);
    idle(9);

    // Burst write across the top of memory; chained reads at the tx_valid drop edge.
    cmd(2'b00, 8'hFE, K_NONE, 8'h00);
    cmd(2'b01, 8'h11, K_NONE, 8'h00);
    cmd(2'b01, 8'h22, K_NONE, 8'h00);
    cmd(2'b01, 8'h33, K_NONE, 8'h00);
    cmd(2'b10, 8'hFE, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'h11);
    idle(7);
    cmd(2'b11, 8'h00, K_RD, 8'h22);
    idle(7);
    cmd(2'b11, 8'h00, K_RD, 8'h33);
    idle(9);

    // Read while busy is rejected; a write during the burst still lands.
    cmd(2'b10, 8'h10, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'hA5);
    idle(2);
    cmd(2'b11, 8'h00, K_ERR, 8'h00);
    cmd(2'b00, 8'h20, K_NONE, 8'h00);
    cmd(2'b01, 8'hC3, K_NONE, 8'h00);
    idle(5);
    cmd(2'b10, 8'h20, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'hC3);
    idle(9);

    // Asynchronous reset in the 4th tx_valid cycle.
    cmd(2'b10, 8'h10, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'hA5);
    idle(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("async_rst_dout", dout, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmd(2'b11, 8'h00, K_ERR, 8'h00);
    cmd(2'b10, 8'h10, K_NONE, 8'h00);
    cmd(2'b11, 8'h00, K_RD, 8'hA5);
    idle(10);

    chk("rd_queue_drained", 8'(rdq.size()), 8'h00);
    chk("err_queue_drained", 8'(errq.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
